// File: rtl/pi1_downconv_pkg.sv
// Shared PerInt definitions for the width down-converter: op encodings
// (identical to pi1q), the clog2 helper and the converter FSM state type.
package pi1_downconv_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } dc_state_e;

endpackage

// File: rtl/pi1_downconv_nxtsel.sv
// Priority encoder: lowest slice index >= start whose byte-select slice is
// nonzero, plus a flag when no such slice remains. Used only when zero-select
// sub-ops are skipped (PI1_DOWNCONV_SKIPNOSEL_EN).
module pi1_downconv_nxtsel
    import pi1_downconv_pkg::*;
#(
    parameter int RATIO = 2,
    parameter int SELW  = 4,
    localparam int IDXW = clog2(RATIO)
) (
    input  logic [RATIO-1:0][SELW-1:0] sel,
    input  logic [IDXW:0]              start,
    output logic [IDXW-1:0]            idx,
    output logic                       none
);

    // Scan downward so the lowest qualifying slice wins.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if ((i >= int'(start)) && (sel[i] != '0)) begin
                idx  = IDXW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pi1_downconv.sv
// PerInt width down-converter: splits one wide op into RATIO narrow sub-ops
// and reassembles read data. Optional macro PI1_DOWNCONV_SKIPNOSEL_EN skips
// sub-ops whose byte-select slice is zero.
//
// state    | meaning
// ST_IDLE  | ready for an upstream op (m_rdy_o=1)
// ST_ISSUE | driving sub-op idx downstream, waiting for s_rdy_i
// ST_DRAIN | all sub-ops issued, collecting the final read slice
module pi1_downconv
    import pi1_downconv_pkg::*;
#(
    parameter int MARCHBITSZ = 64,
    parameter int SARCHBITSZ = 32,
    localparam int RATIO      = MARCHBITSZ / SARCHBITSZ,
    localparam int CLOG2RATIO = clog2(RATIO),
    localparam int MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ / 8),
    localparam int SADDRBITSZ = SARCHBITSZ - clog2(SARCHBITSZ / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                m_op_i,
    input  logic [MADDRBITSZ-1:0]     m_addr_i,
    input  logic [MARCHBITSZ-1:0]     m_data_i,
    input  logic [MARCHBITSZ/8-1:0]   m_sel_i,
    output logic [MARCHBITSZ-1:0]     m_data_o,
    output logic                      m_rdy_o,
    output logic [1:0]                s_op_o,
    output logic [SADDRBITSZ-1:0]     s_addr_o,
    output logic [SARCHBITSZ-1:0]     s_data_o,
    input  logic [SARCHBITSZ-1:0]     s_data_i,
    output logic [SARCHBITSZ/8-1:0]   s_sel_o,
    input  logic                      s_rdy_i
);

    localparam int SSELW = SARCHBITSZ / 8;
    localparam int HADDR = SADDRBITSZ - CLOG2RATIO;
    localparam logic [CLOG2RATIO-1:0] IDX_LAST = CLOG2RATIO'(RATIO - 1);

    dc_state_e                          state;
    logic [1:0]                         op_held;
    logic [HADDR-1:0]                   addr_held;
    logic [RATIO-1:0][SARCHBITSZ-1:0]   data_held;
    logic [RATIO-1:0][SSELW-1:0]        sel_held;
    logic [CLOG2RATIO-1:0]              idx;
    logic [CLOG2RATIO-1:0]              prev_idx;
    logic                               prevrd;
    logic [RATIO-1:0][SARCHBITSZ-1:0]   m_data_r;

    // Upper word-address bits select among wide words only; the narrow slave
    // sees the low bits concatenated with the slice index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^m_addr_i[MADDRBITSZ-1:HADDR];

`ifdef PI1_DOWNCONV_SKIPNOSEL_EN
    logic [CLOG2RATIO-1:0] first_idx;
    logic                  first_none;
    logic [CLOG2RATIO-1:0] next_idx;
    logic                  next_none;
    logic [CLOG2RATIO:0]   next_start;

    assign next_start = {1'b0, idx} + (CLOG2RATIO + 1)'(1);

    pi1_downconv_nxtsel #(
        .RATIO (RATIO),
        .SELW  (SSELW)
    ) u_nxtsel_first (
        .sel   (m_sel_i),
        .start ('0),
        .idx   (first_idx),
        .none  (first_none)
    );

    pi1_downconv_nxtsel #(
        .RATIO (RATIO),
        .SELW  (SSELW)
    ) u_nxtsel_next (
        .sel   (sel_held),
        .start (next_start),
        .idx   (next_idx),
        .none  (next_none)
    );
`endif

    // Sequencing FSM: latch the wide op, walk the slices, gather read data.
    // Read data for a sub-op arrives with the next downstream acceptance,
    // hence the one-slice lag through prev_idx/prevrd.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            idx      <= '0;
            m_data_r <= '0;
            prevrd   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_op_i != PINOOP) begin
                        op_held   <= m_op_i;
                        addr_held <= m_addr_i[HADDR-1:0];
                        data_held <= m_data_i;
                        sel_held  <= m_sel_i;
`ifdef PI1_DOWNCONV_SKIPNOSEL_EN
                        // Skipped read slices must read back as zero.
                        if (m_op_i[1]) begin
                            m_data_r <= '0;
                        end
                        if (!first_none) begin
                            idx   <= first_idx;
                            state <= ST_ISSUE;
                        end
`else
                        idx   <= '0;
                        state <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (s_rdy_i) begin
                        if (prevrd) begin
                            m_data_r[prev_idx] <= s_data_i;
                        end
                        prevrd   <= op_held[1];
                        prev_idx <= idx;
`ifdef PI1_DOWNCONV_SKIPNOSEL_EN
                        if (next_none) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx <= next_idx;
                        end
`else
                        if (idx == IDX_LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx <= idx + CLOG2RATIO'(1);
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    if (s_rdy_i) begin
                        if (prevrd) begin
                            m_data_r[prev_idx] <= s_data_i;
                        end
                        prevrd <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state; reset forces both idle.
    always_comb begin
        m_rdy_o = 1'b0;
        s_op_o  = PINOOP;
        if (!rst_i) begin
            m_rdy_o = (state == ST_IDLE);
            if (state == ST_ISSUE) begin
                s_op_o = op_held;
            end
        end
    end

    assign s_addr_o = {addr_held, idx};
    assign s_data_o = data_held[idx];
    assign s_sel_o  = sel_held[idx];
    assign m_data_o = m_data_r;

endmodule

// File: tb/tb_pi1_downconv.sv
`timescale 1ns/1ps
module tb_pi1_downconv;
    import pi1_downconv_pkg::*;

    localparam int MW = 64, SW = 32, MAW = 61, SAW = 30;
`ifdef PI1_DOWNCONV_SKIPNOSEL_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]     op;
        logic [SAW-1:0] addr;
        logic [SW-1:0]  data;
        logic [3:0]     sel;
    } subop_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [1:0]     m_op_i;
    logic [MAW-1:0] m_addr_i;
    logic [MW-1:0]  m_data_i;
    logic [7:0]     m_sel_i;
    logic [MW-1:0]  m_data_o;
    logic           m_rdy_o;
    logic [1:0]     s_op_o;
    logic [SAW-1:0] s_addr_o;
    logic [SW-1:0]  s_data_o;
    logic [SW-1:0]  s_data_i = '0;
    logic [3:0]     s_sel_o;
    wire            s_rdy_i;

    logic s_rdy_dir = 1'b1, s_rdy_rnd = 1'b1, rand_en = 1'b0;
    assign s_rdy_i = s_rdy_dir & s_rdy_rnd;

    pi1_downconv dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_op_i(m_op_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
        .m_data_o(m_data_o), .m_rdy_o(m_rdy_o),
        .s_op_o(s_op_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_sel_o(s_sel_o), .s_rdy_i(s_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;

    // Upstream-view reference (wide words) and the narrow slave's storage.
    logic [MW-1:0] ref_mem [32] = '{default: '0};
    logic [SW-1:0] slave_mem [64] = '{default: '0};
    subop_t exp_q [$];

    logic          pend_valid = 1'b0;
    logic          pend_chk_lat;
    int            pend_lat, pend_cyc;
    logic [MW-1:0] pend_data;
    logic [MW-1:0] last_exp = '0;

    logic   acc_q = 1'b0, hold_q = 1'b0;
    subop_t cur, hold_v, acc_v;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream sampler, well before the rising edge.
    always begin
        @(negedge clk_i);
        #3;
        cur = '{op: s_op_o, addr: s_addr_o, data: s_data_o, sel: s_sel_o};
        if (!rst_i && hold_q) check("s_stable_in_stall", 72'(cur), 72'(hold_v));
        hold_q = !rst_i && !s_rdy_i && (s_op_o != PINOOP);
        hold_v = cur;
        acc_q  = !rst_i && s_rdy_i && (s_op_o != PINOOP);
        acc_v  = cur;
        if (acc_q) begin
            if (exp_q.size() == 0) check("subop_unexpected", 72'(cur), 72'(0));
            else check("subop", 72'(cur), 72'(exp_q.pop_front()));
        end
    end

    // Pipelined narrow slave: read data appears after the accepting edge.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (acc_q) begin
            if (acc_v.op[1]) s_data_i <= slave_mem[acc_v.addr[5:0]];
            if (acc_v.op[0])
                for (int b = 0; b < 4; b++)
                    if (acc_v.sel[b]) slave_mem[acc_v.addr[5:0]][8*b +: 8] <= acc_v.data[8*b +: 8];
        end
    end

    always @(negedge clk_i) s_rdy_rnd = rand_en ? ($urandom_range(3) != 0) : 1'b1;

    task automatic complete();
        if (pend_valid) begin
            if (pend_chk_lat) check("latency", 72'(cyc - pend_cyc), 72'(pend_lat));
            check("m_data_o", 72'(m_data_o), 72'(pend_data));
            pend_valid = 1'b0;
        end
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [MAW-1:0] a,
                                input logic [MW-1:0] d, input logic [7:0] sel,
                                input logic chk_lat, input int extra);
        logic [MW-1:0] old;
        int nsub;
        nsub = 0;
        for (int i = 0; i < 2; i++) begin
            if (!(SKIP && sel[4*i +: 4] == 4'h0)) begin
                exp_q.push_back('{op: op, addr: {a[SAW-2:0], 1'(i)}, data: d[32*i +: 32], sel: sel[4*i +: 4]});
                nsub++;
            end
        end
        old = ref_mem[a[4:0]];
        if (op[0])
            for (int b = 0; b < 8; b++)
                if (sel[b]) ref_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
        if (op[1]) begin
            last_exp = old;
            if (SKIP)
                for (int i = 0; i < 2; i++)
                    if (sel[4*i +: 4] == 4'h0) last_exp[32*i +: 32] = '0;
        end
        pend_valid   = 1'b1;
        pend_chk_lat = chk_lat;
        pend_lat     = ((nsub == 0) ? 1 : nsub + 2) + extra;
        pend_cyc     = cyc;
        pend_data    = last_exp;
    endtask

    task automatic send(input logic [1:0] op, input logic [MAW-1:0] a, input logic [MW-1:0] d,
                        input logic [7:0] sel, input logic chk_lat, input int extra);
        int n;
        @(negedge clk_i);
        m_op_i = op; m_addr_i = a; m_data_i = d; m_sel_i = sel;
        n = 0;
        while (!m_rdy_o && n < 300) begin @(negedge clk_i); n++; end
        check("rdy_wait", 72'(m_rdy_o), 72'(1));
        complete();
        model_accept(op, a, d, sel, chk_lat, extra);
        @(posedge clk_i);
    endtask

    task automatic idle();
        int n;
        @(negedge clk_i);
        m_op_i = PINOOP;
        n = 0;
        while (!m_rdy_o && n < 300) begin @(negedge clk_i); n++; end
        check("rdy_wait_idle", 72'(m_rdy_o), 72'(1));
        complete();
    endtask

    initial begin
        logic [7:0] rsel;
        rst_i = 1'b1; m_op_i = PINOOP; m_addr_i = '0; m_data_i = '0; m_sel_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_m_rdy", 72'(m_rdy_o), 72'(0));
        check("reset_s_op", 72'(s_op_o), 72'(PINOOP));
        check("reset_m_data", 72'(m_data_o), 72'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_rdy", 72'(m_rdy_o), 72'(1));

        // Preload 0x10, then the basic read.
        send(PIWROP, 61'h10, 64'h22222222_11111111, 8'hFF, 1'b1, 0);
        idle();
        send(PIRDOP, 61'h10, 64'h0, 8'hFF, 1'b1, 0);
        idle();

        // Upper-half-only write, then read it back.
        send(PIWROP, 61'h11, 64'hAAAABBBB_CCCCDDDD, 8'hF0, 1'b1, 0);
        idle();
        send(PIRDOP, 61'h11, 64'h0, 8'hFF, 1'b1, 0);
        idle();

        // Five-cycle stall while sub-op 1 is on the bus.
        send(PIRDOP, 61'h10, 64'h0, 8'hFF, 1'b1, 5);
        @(negedge clk_i);
        @(negedge clk_i);
        s_rdy_dir = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            check("stall_m_rdy", 72'(m_rdy_o), 72'(0));
        end
        s_rdy_dir = 1'b1;
        idle();

        // Reset in the middle of a read.
        send(PIRDOP, 61'h11, 64'h0, 8'hFF, 1'b0, 0);
        @(negedge clk_i);
        rst_i = 1'b1; m_op_i = PINOOP;
        exp_q.delete();
        pend_valid = 1'b0;
        @(negedge clk_i);
        check("midrst_m_rdy", 72'(m_rdy_o), 72'(0));
        check("midrst_s_op", 72'(s_op_o), 72'(PINOOP));
        check("midrst_m_data", 72'(m_data_o), 72'(0));
        last_exp = '0;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_release_rdy", 72'(m_rdy_o), 72'(1));

        // Back-to-back read then write, then confirm the write landed.
        send(PIRDOP, 61'h10, 64'h0, 8'hFF, 1'b1, 0);
        send(PIWROP, 61'h12, 64'h01234567_89ABCDEF, 8'hFF, 1'b1, 0);
        send(PIRDOP, 61'h12, 64'h0, 8'hFF, 1'b1, 0);
        idle();

        // All-zero select read.
        send(PIRDOP, 61'h10, 64'h0, 8'h00, 1'b1, 0);
        idle();

        // Randomised traffic with random downstream stalls.
        rand_en = 1'b1;
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(5))
                0: rsel = 8'hFF;
                1: rsel = 8'h00;
                2: rsel = 8'h0F;
                3: rsel = 8'hF0;
                default: rsel = 8'($urandom);
            endcase
            send(2'($urandom_range(3, 1)), 61'($urandom_range(31)),
                 {32'($urandom), 32'($urandom)}, rsel, 1'b0, 0);
            if ($urandom_range(2) == 0) idle();
        end
        idle();
        rand_en = 1'b0;
        repeat (4) @(negedge clk_i);
        check("subops_all_seen", 72'(exp_q.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
